// File: rtl/fp_align.sv
// fp_align: exponent-alignment stage ahead of the single-precision adder core.
// It picks the larger effective exponent and shifts the other mantissa right one bit per cycle, keeping a sticky LSB.
module fp_align #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    localparam int M_W   = FRAC_W + 4,
    localparam int CNT_W = $clog2(M_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [FRAC_W-1:0] frac_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic [FRAC_W-1:0] frac_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_out,
    output logic [M_W-1:0]   mant_big,
    output logic [M_W-1:0]   mant_small,
    output logic             swap
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Denormals behave as if their exponent were 1.
    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        logic [EXP_W-1:0] r;
        if (e == {EXP_W{1'b0}}) begin
            r = {{(EXP_W-1){1'b0}}, 1'b1};
        end else begin
            r = e;
        end
        return r;
    endfunction

    function automatic logic [M_W-1:0] ext_mant(input logic [EXP_W-1:0] e,
                                                input logic [FRAC_W-1:0] f);
        return {(e != {EXP_W{1'b0}}), f, 3'b000};
    endfunction

    // One-bit right shift that folds the bit shifted out into the sticky LSB.
    function automatic logic [M_W-1:0] sticky_shift(input logic [M_W-1:0] m);
        return {1'b0, m[M_W-1:2], m[1] | m[0]};
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [EXP_W-1:0]  exp_r;
    logic [M_W-1:0]    mant_big_r;
    logic [M_W-1:0]    mant_small_r;
    logic              swap_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [EXP_W-1:0]  eff_a_s;
    logic [EXP_W-1:0]  eff_b_s;
    logic              swap_s;
    logic [EXP_W-1:0]  diff_s;
    logic [EXP_W-1:0]  big_exp_s;
    logic [M_W-1:0]    mant_big_s;
    logic [M_W-1:0]    mant_small_s;
    logic [CNT_W-1:0]  cnt_init_s;
    logic              accept_s;

    // Operand unpack, compare and clamped shift count for the capture cycle.
    always_comb begin
        eff_a_s      = eff_exp(exp_a);
        eff_b_s      = eff_exp(exp_b);
        swap_s       = (eff_b_s > eff_a_s);
        diff_s       = {EXP_W{1'b0}};
        big_exp_s    = {EXP_W{1'b0}};
        mant_big_s   = {M_W{1'b0}};
        mant_small_s = {M_W{1'b0}};
        cnt_init_s   = {CNT_W{1'b0}};
        if (swap_s) begin
            diff_s       = eff_b_s - eff_a_s;
            big_exp_s    = eff_b_s;
            mant_big_s   = ext_mant(exp_b, frac_b);
            mant_small_s = ext_mant(exp_a, frac_a);
        end else begin
            diff_s       = eff_a_s - eff_b_s;
            big_exp_s    = eff_a_s;
            mant_big_s   = ext_mant(exp_a, frac_a);
            mant_small_s = ext_mant(exp_b, frac_b);
        end
        if (32'(diff_s) > 32'(M_W)) begin
            cnt_init_s = CNT_W'(M_W);
        end else begin
            cnt_init_s = CNT_W'(diff_s);
        end
    end

    assign accept_s = in_valid & in_ready_r;

    // Next-state logic for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (cnt_init_s == {CNT_W{1'b0}}) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Datapath: capture on accept, shift while in SHIFT, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_r        <= {EXP_W{1'b0}};
            mant_big_r   <= {M_W{1'b0}};
            mant_small_r <= {M_W{1'b0}};
            swap_r       <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        exp_r        <= big_exp_s;
                        mant_big_r   <= mant_big_s;
                        mant_small_r <= mant_small_s;
                        swap_r       <= swap_s;
                        cnt_r        <= cnt_init_s;
                    end
                end
                ST_SHIFT: begin
                    mant_small_r <= sticky_shift(mant_small_r);
                    cnt_r        <= cnt_r - CNT_W'(1);
                end
                ST_DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign exp_out    = exp_r;
    assign mant_big   = mant_big_r;
    assign mant_small = mant_small_r;
    assign swap       = swap_r;

endmodule

// File: tb/tb_fp_align.sv
// Self-checking bench for fp_align: directed corner cases plus randomized operands
// compared against an arithmetic reference of the alignment rules.
module tb_fp_align;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  exp_a;
    logic [22:0] frac_a;
    logic [7:0]  exp_b;
    logic [22:0] frac_b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_out;
    logic [26:0] mant_big;
    logic [26:0] mant_small;
    logic        swap;

    int n_checks = 0;
    int n_fail   = 0;

    fp_align #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .exp_a      (exp_a),
        .frac_a     (frac_a),
        .exp_b      (exp_b),
        .frac_b     (frac_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .exp_out    (exp_out),
        .mant_big   (mant_big),
        .mant_small (mant_small),
        .swap       (swap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: the small mantissa after d sticky shifts keeps M>>d above bit 0,
    // and bit 0 is the OR of original bits 0..d.
    task automatic ref_model(input logic [7:0] ea, input logic [22:0] fa,
                             input logic [7:0] eb, input logic [22:0] fb,
                             output logic [7:0] e_exp, output logic [26:0] e_big,
                             output logic [26:0] e_small, output logic e_swap,
                             output int e_lat);
        longint ma, mb, ms, sh, mask;
        int va, vb, d;
        va = (ea == 8'd0) ? 1 : int'(ea);
        vb = (eb == 8'd0) ? 1 : int'(eb);
        ma = ((ea != 8'd0) ? (64'd1 << 26) : 64'd0) + (longint'(fa) << 3);
        mb = ((eb != 8'd0) ? (64'd1 << 26) : 64'd0) + (longint'(fb) << 3);
        e_swap = (vb > va);
        if (e_swap) begin
            d = vb - va; e_exp = 8'(vb); e_big = 27'(mb); ms = ma;
        end else begin
            d = va - vb; e_exp = 8'(va); e_big = 27'(ma); ms = mb;
        end
        if (d > 27) d = 27;
        sh   = ms >> d;
        mask = (64'd1 << (d + 1)) - 64'd1;
        e_small = 27'((sh & ~64'd1) | (((ms & mask) != 64'd0) ? 64'd1 : 64'd0));
        e_lat = d;
    endtask

    task automatic run_op(input logic [7:0] ea, input logic [22:0] fa,
                          input logic [7:0] eb, input logic [22:0] fb, input int stall);
        logic [7:0]  e_exp;
        logic [26:0] e_big, e_small;
        logic        e_swap;
        int          e_lat, lat, guard;
        ref_model(ea, fa, eb, fb, e_exp, e_big, e_small, e_swap, e_lat);
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("ready_wait", {63'd0, in_ready}, 64'd1);
        exp_a = ea; frac_a = fa; exp_b = eb; frac_b = fb; in_valid = 1'b1;
        @(posedge clk); #1;
        // Scribble on the inputs while busy; none of it may be captured.
        in_valid = 1'($urandom_range(0, 1));
        exp_a = 8'($urandom); frac_a = 23'($urandom); exp_b = 8'($urandom); frac_b = 23'($urandom);
        check_eq("in_ready_busy", {63'd0, in_ready}, 64'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", 64'(lat), 64'(e_lat));
        check_eq("exp_out", {56'd0, exp_out}, {56'd0, e_exp});
        check_eq("swap", {63'd0, swap}, {63'd0, e_swap});
        check_eq("mant_big", {37'd0, mant_big}, {37'd0, e_big});
        check_eq("mant_small", {37'd0, mant_small}, {37'd0, e_small});
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check_eq("stall_valid", {63'd0, out_valid}, 64'd1);
            check_eq("stall_ready", {63'd0, in_ready}, 64'd0);
            check_eq("stall_small", {37'd0, mant_small}, {37'd0, e_small});
            check_eq("stall_big", {37'd0, mant_big}, {37'd0, e_big});
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        check_eq("hs_valid", {63'd0, out_valid}, 64'd0);
        check_eq("hs_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_a = 8'd0; frac_a = 23'd0; exp_b = 8'd0; frac_b = 23'd0;
        #12;
        check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_exp", {56'd0, exp_out}, 64'd0);
        check_eq("rst_small", {37'd0, mant_small}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h81, 23'h0,      8'h80, 23'h0, 0);
        run_op(8'h7F, 23'h0,      8'h82, 23'h0, 10);
        run_op(8'h80, 23'h000001, 8'h84, 23'h0, 0);
        run_op(8'hFE, 23'h0,      8'h01, 23'h0, 2);
        run_op(8'h00, 23'h400000, 8'h01, 23'h0, 0);
        run_op(8'hFF, 23'h7FFFFF, 8'hFF, 23'h000001, 1);

        // Abort mid-shift: reset must clear everything immediately.
        @(negedge clk);
        exp_a = 8'hFE; frac_a = 23'h123456; exp_b = 8'h01; frac_b = 23'h654321; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("abort_valid", {63'd0, out_valid}, 64'd0);
        check_eq("abort_ready", {63'd0, in_ready}, 64'd1);
        check_eq("abort_exp", {56'd0, exp_out}, 64'd0);
        check_eq("abort_big", {37'd0, mant_big}, 64'd0);
        check_eq("abort_small", {37'd0, mant_small}, 64'd0);
        check_eq("abort_swap", {63'd0, swap}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 40; k++) begin
            logic [7:0]  ra, rb;
            logic [22:0] fa, fb;
            ra = 8'($urandom);
            if (k % 3 == 0) rb = 8'($urandom);
            else rb = 8'(int'(ra) + $urandom_range(0, 40) - 20);
            if (k % 7 == 0) ra = 8'd0;
            fa = 23'($urandom);
            fb = 23'($urandom);
            run_op(ra, fa, rb, fb, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_align.md
Name: fp_align

Overview:
- Pre-add exponent-alignment stage for the single-precision FP adder. It does the inverse of post-add normalization.
- Takes two unpacked operands and selects the larger effective exponent.
- Right-shifts the smaller operand's mantissa one bit per cycle, preserving guard/round/sticky.
- Presents both aligned mantissas to the adder core through a valid/ready handshake.

Parameters:
EXP_W, 8, exponent width
FRAC_W, 23, stored fraction width; extended mantissa width M_W = FRAC_W+4 (hidden + fraction + G,R,S)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
exp_a  input  EXP_W  biased exponent of A
frac_a  input  FRAC_W  fraction of A
exp_b  input  EXP_W  biased exponent of B
frac_b  input  FRAC_W  fraction of B
out_valid  output  1  aligned result valid
out_ready  input  1  downstream accepts result
exp_out  output  EXP_W  common (larger effective) exponent
mant_big  output  M_W  {hidden, frac, 3'b000} of larger-exponent operand
mant_small  output  M_W  aligned mantissa of the other operand; LSB is sticky
swap  output  1  1 = B was the larger-exponent operand

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, and exp_out, mant_big, mant_small, swap, and the shift counter all cleared to 0. Reset asserted mid-SHIFT or mid-DONE aborts the operation; no partial result is ever emitted.
- Unpack:
  - hidden = (exp != 0).
  - Effective exponent = (exp == 0) ? 1 : exp.
  - Extended mantissa M = {hidden, frac, 3'b000}.
- Compare: swap = (eff_b > eff_a). On equal exponents A is the big operand (swap=0); fractions are not compared.
- Shift count: diff = e_big - e_small, clamped to M_W (27).
- FSM:
  - IDLE: in_ready=1. On in_valid & in_ready, register mant_big, mant_small (unshifted), exp_out, swap, cnt=clamped diff. Next state is DONE if cnt==0, else SHIFT.
  - SHIFT: in_ready=0, out_valid=0. Each edge: mant_small <= {1'b0, mant_small[M_W-1:2], mant_small[1] | mant_small[0]}, i.e. right-shift by one with the bit shifted out ORed into the LSB (sticky). cnt <= cnt-1; go to DONE when cnt==1.
  - DONE: out_valid=1, all outputs held stable. On out_ready=1, go to IDLE on that edge. No change while out_ready=0.
- Latency: out_valid rises min(diff,27) edges after the accept edge (diff=0: immediately after the accept edge).
- Throughput: in_ready is IDLE-only, so there is always ≥1 idle cycle between the output handshake and the next accept.
- in_valid outside IDLE is ignored; operands are captured only at accept.
- Clamp: a shift of 27 drives all significant bits to 0 with sticky=1 whenever the original mantissa was nonzero.
- NaN/Inf are not special-cased: exponent 0xFF is treated as an ordinary exponent.

Test Plan:
1. A exp=0x81 frac=0, B exp=0x80 frac=0 -> out_valid 1 edge after accept; exp_out=0x81, swap=0, mant_big=27'h4000000, mant_small=27'h2000000.
2. A exp=0x7F frac=0, B exp=0x82 frac=0 -> out_valid 3 edges after accept; swap=1, exp_out=0x82, mant_big=27'h4000000, mant_small=27'h0800000.
3. Sticky: A exp=0x80 frac=23'h000001, B exp=0x84 frac=0 -> after 4 edges swap=1, mant_small=27'h0400001.
4. Clamp: A exp=0xFE, B exp=0x01, both frac=0 -> cnt=27, out_valid after 27 edges; exp_out=0xFE, mant_small=27'h0000001.
5. Denormal/tie: A exp=0x00 frac=23'h400000, B exp=0x01 frac=0 -> out_valid immediately after accept; exp_out=0x01, swap=0, mant_big=27'h2000000, mant_small=27'h4000000.
6. Backpressure and reset:
   - Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0. Then out_ready=1 -> IDLE and in_ready=1 on the next edge.
   - Separately, pulse rst_n=0 mid-SHIFT -> out_valid=0 and in_ready=1 immediately, all outputs 0.
